branch_history_table: RTL
=========================

# branch_history_table

Direction predictor for conditional branches, sitting downstream of the branch unit. It consumes the resolved-branch outcome produced in execute and trains a table of 2-bit saturating counters. The frontend indexes the same table with the fetch PC to obtain a taken/not-taken prediction. A flush walks the table and invalidates it one entry per cycle.

## Interface
- NR_ENTRIES, 1024: number of table entries; power of two, ≥ 4.
- INDEX_W, $clog2(NR_ENTRIES): derived localparam; not overridable.

- clk_i  input  1  clock; all state changes on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- flush_i  input  1  start (or restart) table invalidation.
- vpc_i  input  64  fetch PC to predict.
- bht_update_i  input  bht_update_t  {valid, pc[63:0], taken}; driven from the resolved branch when it is a valid conditional branch and not a clear.
- bht_prediction_o  output  bht_prediction_t  {valid, taken} for vpc_i.
- busy_o  output  1  high while flush walk is in progress.

## Operation
- Index is vpc_i[INDEX_W:1] for lookup and bht_update_i.pc[INDEX_W:1] for update. Bit 0 is ignored; compressed and 4-byte-aligned PCs share the scheme.
- Each entry holds a valid bit and a 2-bit counter: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup is combinational.
  - bht_prediction_o.valid = entry.valid && !busy_o.
  - bht_prediction_o.taken = entry.counter[1] && prediction valid.
- Update, applied when bht_update_i.valid and state is IDLE and flush_i is low:
  - Invalid entry: set valid; counter = taken ? 10 : 01.
  - Valid entry: taken increments the counter, saturating at 11; not taken decrements it, saturating at 00.
- Flush FSM states:
  - IDLE: flush_i → FLUSH, with walk pointer = 0.
  - FLUSH: each cycle, clear valid and counter of entry[ptr]; ptr increments. When ptr == NR_ENTRIES-1 and that entry is cleared → IDLE.
  - flush_i in FLUSH: ptr restarts at 0.
- busy_o = (state == FLUSH).
- Updates arriving in the flush_i cycle or while busy are dropped; there is no queueing.

## Timing
- Reset values: all entries valid=0 and counter=00, state IDLE, ptr 0. Outputs: busy_o 0, prediction {0,0}.
- Reset mid-flush aborts to IDLE with the table fully cleared.
- Update latency: the table is written at the edge ending the cycle in which bht_update_i.valid is high. A lookup of that index in the next cycle sees the new value.
- Lookup and update to the same index in the same cycle return the pre-update value, unless BHT_BYPASS_EN is defined.
- Flush latency: flush_i high in cycle 0 → busy_o high in cycles 1..NR_ENTRIES → busy_o low in cycle NR_ENTRIES+1.
- Only one table write per cycle. The flush walk and the update path never write in the same cycle.

## Configuration
- BHT_BYPASS_EN:
  - Defined: when an update is accepted and its index equals the lookup index, bht_prediction_o reflects the post-update entry in that same cycle.
  - Undefined: bht_prediction_o reflects the stored (pre-update) entry.

## Structure
- ariane_pkg holds the bht_update_t and bht_prediction_t typedefs and the BHT_NR_ENTRIES default constant.
- Sub-module bht_sat_counter is combinational: (valid, counter, taken) → (next valid, next counter). It is used by the update path and by the bypass path.
- The table is a flop array so that reset can be asynchronous.

## Test plan
- Reset, then lookup vpc_i=0x1000 → prediction {0,0} and busy_o 0.
- Update pc=0x1000 taken once → next cycle lookup 0x1000 returns {1,1} with counter 10. Two not-taken updates → {1,0} with counter 00. A third not-taken update → counter stays 00.
- Four taken updates on pc=0x2002 → counter saturates at 11. Lookup 0x2002+2*NR_ENTRIES (aliasing index) → same prediction.
- flush_i for one cycle with NR_ENTRIES=1024 → busy_o high for exactly 1024 cycles, predictions valid=0 throughout, all entries invalid afterwards. A concurrent update at cycle 500 is dropped.
- flush_i reasserted at walk cycle 300 → busy_o extends to 1024 cycles after the reassertion. rst_ni low mid-walk → busy_o 0 immediately and table cleared.
- Same-cycle update taken and lookup to an invalid entry at pc=0x3000 → prediction {0,0} without BHT_BYPASS_EN; {1,1} with it.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared frontend types for the branch history table: update/prediction records,
// the table entry layout and the flush FSM states.
package ariane_pkg;

  localparam int unsigned BHT_NR_ENTRIES = 1024;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        taken;
  } bht_update_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] counter;
  } bht_entry_t;

  typedef enum logic {
    BHT_IDLE,
    BHT_FLUSH
  } bht_state_e;

endpackage

// File: rtl/bht_sat_counter.sv
// Next-state function of one BHT entry: first touch seeds a weak counter,
// later outcomes move a 2-bit counter that saturates at both ends.
module bht_sat_counter (
  input  logic       valid_i,
  input  logic [1:0] counter_i,
  input  logic       taken_i,
  output logic       valid_o,
  output logic [1:0] counter_o
);

  always_comb begin
    valid_o   = 1'b1;
    counter_o = counter_i;
    if (!valid_i) begin
      counter_o = taken_i ? 2'b10 : 2'b01;
    end else if (taken_i) begin
      if (counter_i != 2'b11) counter_o = counter_i + 2'd1;
    end else begin
      if (counter_i != 2'b00) counter_o = counter_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating direction predictor with a one-entry-per-cycle
// flush walk. Define BHT_BYPASS_EN to forward a same-cycle update to the lookup.
module branch_history_table
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = BHT_NR_ENTRIES
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [63:0]     vpc_i,
  input  bht_update_t     bht_update_i,
  output bht_prediction_t bht_prediction_o,
  output logic            busy_o
);

  localparam int unsigned        INDEX_W  = $clog2(NR_ENTRIES);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NR_ENTRIES - 1);

  bht_entry_t         table_q [NR_ENTRIES];
  bht_state_e         state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;

  logic [INDEX_W-1:0] lookup_idx;
  logic [INDEX_W-1:0] update_idx;
  bht_entry_t         update_entry;
  bht_entry_t         lookup_entry;
  logic               next_valid;
  logic [1:0]         next_counter;
  logic               flush_wr;
  logic               update_wr;
  logic               pred_valid;
  logic               unused_bits;

  // Bit 0 is dropped so compressed and word-aligned PCs index the same way.
  assign lookup_idx  = vpc_i[INDEX_W:1];
  assign update_idx  = bht_update_i.pc[INDEX_W:1];
  assign unused_bits = ^{vpc_i[63:INDEX_W+1], vpc_i[0],
                         bht_update_i.pc[63:INDEX_W+1], bht_update_i.pc[0]};

  assign update_entry = table_q[update_idx];

  bht_sat_counter u_sat_counter (
    .valid_i   (update_entry.valid),
    .counter_i (update_entry.counter),
    .taken_i   (bht_update_i.taken),
    .valid_o   (next_valid),
    .counter_o (next_counter)
  );

  assign busy_o    = (state_q == BHT_FLUSH);
  assign update_wr = bht_update_i.valid && (state_q == BHT_IDLE) && !flush_i;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    flush_wr = 1'b0;
    unique case (state_q)
      BHT_IDLE: begin
        if (flush_i) begin
          state_d = BHT_FLUSH;
          ptr_d   = '0;
        end
      end
      BHT_FLUSH: begin
        flush_wr = 1'b1;
        if (flush_i) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_IDX) begin
          state_d = BHT_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + INDEX_W'(1);
        end
      end
      default: begin
        state_d = BHT_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    lookup_entry = table_q[lookup_idx];
`ifdef BHT_BYPASS_EN
    if (update_wr && (update_idx == lookup_idx)) begin
      lookup_entry.valid   = next_valid;
      lookup_entry.counter = next_counter;
    end
`endif
  end

  assign pred_valid             = lookup_entry.valid && !busy_o;
  assign bht_prediction_o.valid = pred_valid;
  assign bht_prediction_o.taken = lookup_entry.counter[1] && pred_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BHT_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Flops rather than SRAM so the whole table clears on the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        table_q[i] <= '0;
      end
    end else if (flush_wr) begin
      table_q[ptr_q] <= '0;
    end else if (update_wr) begin
      table_q[update_idx].valid   <= next_valid;
      table_q[update_idx].counter <= next_counter;
    end
  end

endmodule
